// File: rtl/regfile_wport_sched.sv
// Shares the register-file write port between the pipeline and muldiv writebacks
// using round-robin arbitration, and tracks outstanding muldiv destinations in a busy scoreboard.
module regfile_wport_sched #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p_valid,
  input  logic [AW-1:0]     p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              m_valid,
  input  logic [AW-1:0]     m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_ready,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic              stall,
  output logic [AW-1:0]     a3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3
);

  // last_grant_m is 1 when the muldiv unit won the most recent transfer
  logic            last_grant_m;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            grant_p;
  logic            grant_m;
  logic            claim_take;

  always_comb begin
    grant_p = p_valid && (!m_valid || last_grant_m);
    grant_m = m_valid && (!p_valid || !last_grant_m);
  end

  assign p_ready = grant_p;
  assign m_ready = grant_m;

  // Write port follows the winner; address 0 handshakes but never writes
  always_comb begin
    a3  = '0;
    wd3 = '0;
    if (grant_p) begin
      a3  = p_addr;
      wd3 = p_data;
    end else if (grant_m) begin
      a3  = m_addr;
      wd3 = m_data;
    end
    we3 = (grant_p || grant_m) && (a3 != '0);
  end

  assign claim_ready = !busy[claim_addr] || (claim_addr == '0);
  assign claim_take  = claim_valid && claim_ready && (claim_addr != '0);

  // A claim is applied after the muldiv clear so a same-address set wins
  always_comb begin
    busy_nxt = busy;
    if (grant_m)
      busy_nxt[m_addr] = 1'b0;
    if (claim_take)
      busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stall looks only at registered state; the register file writes at the edge
  assign stall = busy[rs_addr] || busy[rt_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      last_grant_m <= 1'b1;
    end else begin
      busy <= busy_nxt;
      if (grant_p)
        last_grant_m <= 1'b0;
      else if (grant_m)
        last_grant_m <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Bench for regfile_wport_sched: expected write-port activity is queued as stimulus
// is driven and popped when the combinational outputs are sampled.
module tb_regfile_wport_sched;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_data = '0;
  logic        p_ready;
  logic        m_valid = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_ready;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_addr = '0;
  logic        claim_ready;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        stall;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;

  // {p_ready, m_ready, we3, a3, wd3}
  typedef logic [39:0] wexp_t;
  wexp_t sbq[$];
  wexp_t got;
  wexp_t exp_w;

  int errors = 0;
  int checks = 0;

  regfile_wport_sched dut (
    .clock(clock), .reset_n(reset_n),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
    .a3(a3), .wd3(wd3), .we3(we3)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    p_valid = 1'b0; p_addr = '0; p_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    rs_addr = '0; rt_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset_n = 1'b0;
    p_valid = 1'b0;
    sbq.push_back({1'b0, 1'b0, 1'b0, 5'd0, 32'h0});
    rs_addr = 5'd3; rt_addr = 5'd9; claim_addr = 5'd9;
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL reset_wport got=%h required=%h", got, exp_w); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b required=0", stall); end
    checks++;
    if (claim_ready !== 1'b1) begin errors++; $display("FAIL reset_claim_ready got=%b required=1", claim_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_write();
    @(negedge clock);
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hDEADBEEF;
    sbq.push_back({1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF});
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL single_write got=%h required=%h", got, exp_w); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_alternate();
    int pc;
    int mc;
    pc = 0; mc = 0;
    @(negedge clock);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    p_valid = 1'b1; p_addr = 5'd7;
    m_valid = 1'b1; m_addr = 5'd8;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      p_data = 32'hA000_0000 | pc;
      m_data = 32'hB000_0000 | mc;
      if (i % 2 == 0) begin
        sbq.push_back({1'b1, 1'b0, 1'b1, 5'd7, 32'hA000_0000 | pc});
        pc++;
      end else begin
        sbq.push_back({1'b0, 1'b1, 1'b1, 5'd8, 32'hB000_0000 | mc});
        mc++;
      end
      #1;
      got = {p_ready, m_ready, we3, a3, wd3};
      exp_w = sbq.pop_front();
      checks++;
      if (got !== exp_w) begin errors++; $display("FAIL alternate_%0d got=%h required=%h", i, got, exp_w); end
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    claim_valid = 1'b1; claim_addr = 5'd9; rs_addr = 5'd9;
    #1;
    checks++;
    if (claim_ready !== 1'b1) begin errors++; $display("FAIL claim9_ready got=%b required=1", claim_ready); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL claim9_same_cycle_stall got=%b required=0", stall); end
    @(negedge clock);
    claim_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL claim9_stall got=%b required=1", stall); end
    @(negedge clock);
    claim_valid = 1'b1; claim_addr = 5'd9;
    #1;
    checks++;
    if (claim_ready !== 1'b0) begin errors++; $display("FAIL reclaim9_ready got=%b required=0", claim_ready); end
    @(negedge clock);
    claim_valid = 1'b0;
    m_valid = 1'b1; m_addr = 5'd9; m_data = 32'hCAFE0009;
    sbq.push_back({1'b0, 1'b1, 1'b1, 5'd9, 32'hCAFE0009});
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL m9_write got=%h required=%h", got, exp_w); end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL m9_accept_cycle_stall got=%b required=1", stall); end
    @(negedge clock);
    m_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL m9_cleared_stall got=%b required=0", stall); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    @(negedge clock);
    claim_valid = 1'b1; claim_addr = 5'd12;
    m_valid = 1'b1; m_addr = 5'd12; m_data = 32'h1234_5678;
    sbq.push_back({1'b0, 1'b1, 1'b1, 5'd12, 32'h1234_5678});
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL setclr12_write got=%h required=%h", got, exp_w); end
    @(negedge clock);
    idle_inputs();
    rt_addr = 5'd12;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL setclr12_stall got=%b required=1", stall); end
    @(negedge clock);
    m_valid = 1'b1; m_addr = 5'd12; m_data = 32'h0000_0012;
    @(negedge clock);
    m_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL clear12_stall got=%b required=0", stall); end
    idle_inputs();
  endtask

  task automatic test_reg0();
    @(negedge clock);
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hFFFFFFFF;
    claim_valid = 1'b1; claim_addr = 5'd0;
    sbq.push_back({1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF});
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL reg0_pwrite got=%h required=%h", got, exp_w); end
    checks++;
    if (claim_ready !== 1'b1) begin errors++; $display("FAIL reg0_claim_ready got=%b required=1", claim_ready); end
    @(negedge clock);
    p_valid = 1'b0; claim_valid = 1'b0;
    rs_addr = 5'd0;
    m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h5555AAAA;
    sbq.push_back({1'b0, 1'b1, 1'b0, 5'd0, 32'h5555AAAA});
    #1;
    got = {p_ready, m_ready, we3, a3, wd3};
    exp_w = sbq.pop_front();
    checks++;
    if (got !== exp_w) begin errors++; $display("FAIL reg0_mwrite got=%h required=%h", got, exp_w); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reg0_stall got=%b required=0", stall); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    claim_valid = 1'b1; claim_addr = 5'd3;
    @(negedge clock);
    claim_valid = 1'b0; rs_addr = 5'd3;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL busy3_stall got=%b required=1", stall); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got=%b required=0", stall); end
    checks++;
    if (claim_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_claim_ready got=%b required=1", claim_ready); end
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL after_reset_stall got=%b required=0", stall); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_scoreboard();
    test_same_cycle();
    test_reg0();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d required=0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wport_sched.md
# regfile_wport_sched

Write-port scheduler for the 32×32 MIPS register file. It shares the single write port (a3/wd3/we3) between two writeback sources: the in-order pipeline writeback and the multi-cycle multiply/divide unit. Conflicts are resolved round-robin. A 32-entry busy scoreboard tracks outstanding multi-cycle destinations and raises read-hazard stalls for the decode stage. The block sits between the pipeline/muldiv writeback stages and the register file.

## Interface
- NREG, 32, number of architectural registers; fixed at 32, address width 5
- clock  in  1  rising-edge clock shared with the register file
- reset_n  in  1  asynchronous, active-low reset
- p_valid  in  1  pipeline writeback request
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle
- m_valid  in  1  muldiv writeback request
- m_addr  in  5  muldiv destination register
- m_data  in  32  muldiv write data
- m_ready  out  1  muldiv request accepted this cycle
- claim_valid  in  1  muldiv op issuing, reserving claim_addr
- claim_addr  in  5  destination reserved by the issuing op
- claim_ready  out  1  reservation accepted
- rs_addr, rt_addr  in  5 each  decode-stage source addresses
- stall  out  1  decode must hold: a source is busy
- a3  out  5  register file write address
- wd3  out  32  register file write data
- we3  out  1  register file write enable

## Operation
- Handshake: a request transfers when valid && ready are both high at a rising edge. The requester holds valid, addr and data stable until it is accepted.
- Arbitration is combinational in the current cycle:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - last_grant updates only on a transfer.
- Ready outputs: p_ready = grant to pipeline, m_ready = grant to muldiv. At most one is high in any cycle.
- Write port: a3/wd3 follow the granted request. we3 = (a grant exists) && (a3 != 0). When there is no grant, a3 = 0, wd3 = 0, we3 = 0.
- Register 0: a request with addr 0 still handshakes (ready high) but never asserts we3.
- Scoreboard busy[31:0], with busy[0] hardwired to 0:
  - claim_ready = !busy[claim_addr] || claim_addr == 0.
  - A claim with claim_valid && claim_ready && claim_addr != 0 sets busy[claim_addr] at the edge.
  - An accepted muldiv transfer clears busy[m_addr] at the edge.
  - Same address set and cleared in the same cycle: set wins.
- Pipeline transfers never modify the scoreboard.
- stall = busy[rs_addr] || busy[rt_addr]. It uses registered state only; same-cycle writes are not bypassed, because the register file writes at the edge.

## Timing
- Reset (async assert, sync-safe release): busy = 0, last_grant = muldiv (so the pipeline wins the first conflict), we3 = 0, a3 = 0, wd3 = 0, stall = 0, p_ready = m_ready = 0 unless a valid is present.
- p_ready, m_ready, claim_ready, stall and the write port are combinational from inputs and registered state. Write latency is 0 cycles: data is written at the acceptance edge.
- busy and last_grant update at the rising clock edge.
- Worst-case wait for a continuously valid requester: 1 cycle.
- Reset asserted mid-operation clears all outstanding reservations. Requesters must re-issue.

## Test plan
- Reset, then p_valid with p_addr=5, p_data=0xDEADBEEF and no other traffic -> same cycle p_ready=1, we3=1, a3=5, wd3=0xDEADBEEF.
- p_valid and m_valid held together for 4 cycles with distinct addresses -> grants alternate P, M, P, M, and we3 stays high every cycle.
- Claim addr 9, then decode with rs_addr=9 -> stall=1 from the next cycle. After m_valid/m_addr=9 is accepted, stall=0 the cycle after the edge. A second claim of 9 while busy -> claim_ready=0.
- Claim 12 and m writeback of 12 in the same cycle -> busy[12] stays 1.
- p_valid with p_addr=0, p_data=0xFFFFFFFF -> p_ready=1, we3=0. Claim_addr=0 -> claim_ready=1, and stall never asserts for rs_addr=0.
- busy[3] set, then reset_n pulsed low mid-cycle -> busy clears immediately, and stall for rs_addr=3 is 0.
